// File: rtl/simmem_pkg.sv
// -----------------------------------------------------------------------------
// simmem_pkg
// Shared types and constants for the simulated memory controller.
//
// Contents:
//   delay_entry_state_e : per-entry lifecycle of a delay tracker slot
//   DelayTracker*       : default tracker geometry
//   Read*/Write*        : per-bank instantiation values for the two paths
// -----------------------------------------------------------------------------
package simmem_pkg;

  // Lifecycle of one delay tracker entry.
  typedef enum logic [1:0] {
    DELAY_FREE       = 2'd0,
    DELAY_COUNTING   = 2'd1,
    DELAY_RELEASABLE = 2'd2
  } delay_entry_state_e;

  // Default tracker geometry.
  localparam int unsigned DelayTrackerCapacity      = 32'd16;
  localparam int unsigned DelayTrackerNumInputs     = 32'd2;
  localparam int unsigned DelayTrackerDelayWidth    = 32'd6;
  localparam int unsigned DelayTrackerReleaseOffset = 32'd2;

  // Read response path: wider bank, two reservation ports.
  localparam int unsigned ReadDelayTrackerNumEntries    = 32'd16;
  localparam int unsigned ReadDelayTrackerNumInputs     = 32'd2;
  localparam int unsigned ReadDelayTrackerReleaseOffset = 32'd2;

  // Write response path: smaller bank, single reservation port.
  localparam int unsigned WriteDelayTrackerNumEntries    = 32'd8;
  localparam int unsigned WriteDelayTrackerNumInputs     = 32'd1;
  localparam int unsigned WriteDelayTrackerReleaseOffset = 32'd2;

endpackage

// File: rtl/simmem_delay_tracker_entry.sv
// -----------------------------------------------------------------------------
// simmem_delay_tracker_entry
// One tracked entry: FREE -> COUNTING -> RELEASABLE -> FREE, with a delay
// counter that only moves on tick.
//
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   tick_i         : count enable
//   load_i         : reservation accepted for this entry (only while FREE)
//   load_delay_i   : requested delay of the accepted reservation
//   release_i      : bank acknowledges release
//   release_en_o   : entry is RELEASABLE (registered)
//   occupied_o     : entry is not FREE (registered)
// -----------------------------------------------------------------------------
module simmem_delay_tracker_entry
  import simmem_pkg::*;
#(
  parameter int unsigned DelayWidth    = DelayTrackerDelayWidth,
  parameter int unsigned ReleaseOffset = DelayTrackerReleaseOffset
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tick_i,
  input  logic                  load_i,
  input  logic [DelayWidth-1:0] load_delay_i,
  input  logic                  release_i,
  output logic                  release_en_o,
  output logic                  occupied_o
);

  localparam logic [DelayWidth-1:0] Offset   = DelayWidth'(ReleaseOffset);
  localparam logic [DelayWidth-1:0] CountOne = DelayWidth'(1);

  delay_entry_state_e    state_r;
  delay_entry_state_e    state_s;
  logic [DelayWidth-1:0] count_r;
  logic [DelayWidth-1:0] count_s;
  logic                  release_en_r;
  logic                  occupied_r;

  // Next-state and next-count logic for the entry lifecycle.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    case (state_r)
      DELAY_FREE: begin
        if (load_i) begin
          // Delays already covered by pipeline latency release immediately;
          // otherwise D > Offset so the subtraction cannot wrap.
          if (load_delay_i <= Offset) begin
            state_s = DELAY_RELEASABLE;
            count_s = '0;
          end else begin
            state_s = DELAY_COUNTING;
            count_s = load_delay_i - Offset;
          end
        end else begin
          state_s = DELAY_FREE;
          count_s = count_r;
        end
      end
      DELAY_COUNTING: begin
        if (tick_i) begin
          if (count_r == CountOne) begin
            state_s = DELAY_RELEASABLE;
            count_s = '0;
          end else begin
            state_s = DELAY_COUNTING;
            count_s = count_r - CountOne;
          end
        end else begin
          state_s = DELAY_COUNTING;
          count_s = count_r;
        end
      end
      DELAY_RELEASABLE: begin
        if (release_i) begin
          state_s = DELAY_FREE;
          count_s = '0;
        end else begin
          state_s = DELAY_RELEASABLE;
          count_s = count_r;
        end
      end
      default: begin
        state_s = DELAY_FREE;
        count_s = '0;
      end
    endcase
  end

  // State, counter and registered status flags derived from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= DELAY_FREE;
      count_r      <= '0;
      release_en_r <= 1'b0;
      occupied_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      count_r      <= count_s;
      release_en_r <= (state_s == DELAY_RELEASABLE);
      occupied_r   <= (state_s != DELAY_FREE);
    end
  end

  assign release_en_o = release_en_r;
  assign occupied_o   = occupied_r;

endmodule

// File: rtl/simmem_delay_tracker.sv
// -----------------------------------------------------------------------------
// simmem_delay_tracker
// Multi-port delay reservation tracker for a response bank. Arbitrates up to
// NumInputs reservations per cycle onto NumEntries independent delay entries.
//
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   tick_i             : global count enable
//   in_valid_i         : reservation request per port
//   in_id_i            : target entry per port
//   in_delay_i         : requested delay per port
//   collision_o        : registered pulse, port's request was dropped
//   released_onehot_i  : bank releases entries (multi-hot)
//   release_en_o       : entry is releasable
//   occupied_o         : entry is not FREE
//   num_pending_o      : population count of occupied_o
// -----------------------------------------------------------------------------
module simmem_delay_tracker
  import simmem_pkg::*;
#(
  parameter int unsigned NumEntries    = DelayTrackerCapacity,
  parameter int unsigned NumInputs     = DelayTrackerNumInputs,
  parameter int unsigned DelayWidth    = DelayTrackerDelayWidth,
  parameter int unsigned ReleaseOffset = DelayTrackerReleaseOffset,
  parameter int unsigned IdWidth       = $clog2(NumEntries)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 tick_i,
  input  logic [NumInputs-1:0]                 in_valid_i,
  input  logic [NumInputs-1:0][IdWidth-1:0]    in_id_i,
  input  logic [NumInputs-1:0][DelayWidth-1:0] in_delay_i,
  output logic [NumInputs-1:0]                 collision_o,
  input  logic [NumEntries-1:0]                released_onehot_i,
  output logic [NumEntries-1:0]                release_en_o,
  output logic [NumEntries-1:0]                occupied_o,
  output logic [$clog2(NumEntries+1)-1:0]      num_pending_o
);

  localparam int unsigned PendWidth = $clog2(NumEntries + 1);

  logic [NumEntries-1:0]                 occupied_s;
  logic [NumEntries-1:0]                 release_en_s;
  logic [NumEntries-1:0]                 load_s;
  logic [NumEntries-1:0][DelayWidth-1:0] load_delay_s;
  logic [NumInputs-1:0]                  collision_s;
  logic [NumInputs-1:0]                  collision_r;
  logic                                  hit_s;
  logic                                  match_s;
  logic [PendWidth-1:0]                  pending_s;

  // Port arbitration: ports are scanned in index order and load_s doubles as
  // the "already claimed this cycle" mark, so the lowest port wins an entry.
  // An id beyond NumEntries matches no entry and therefore collides.
  always_comb begin
    load_s       = '0;
    load_delay_s = '0;
    collision_s  = '0;
    hit_s        = 1'b0;
    match_s      = 1'b0;
    for (int k = 0; k < NumInputs; k++) begin
      hit_s = 1'b0;
      for (int e = 0; e < NumEntries; e++) begin
        match_s         = in_valid_i[k] && (in_id_i[k] == IdWidth'(e)) &&
                          !occupied_s[e] && !load_s[e];
        load_s[e]       = load_s[e] | match_s;
        load_delay_s[e] = match_s ? in_delay_i[k] : load_delay_s[e];
        hit_s           = hit_s | match_s;
      end
      collision_s[k] = in_valid_i[k] & ~hit_s;
    end
  end

  // Collision pulses are reported one cycle after the dropped request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      collision_r <= '0;
    end else begin
      collision_r <= collision_s;
    end
  end

  for (genvar i = 0; i < NumEntries; i++) begin : g_entry
    simmem_delay_tracker_entry #(
      .DelayWidth    (DelayWidth),
      .ReleaseOffset (ReleaseOffset)
    ) u_entry (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .tick_i       (tick_i),
      .load_i       (load_s[i]),
      .load_delay_i (load_delay_s[i]),
      .release_i    (released_onehot_i[i]),
      .release_en_o (release_en_s[i]),
      .occupied_o   (occupied_s[i])
    );
  end

  // Population count of occupied entries, driven only by registered flags.
  always_comb begin
    pending_s = '0;
    for (int e = 0; e < NumEntries; e++) begin
      pending_s = pending_s + PendWidth'(occupied_s[e]);
    end
  end

  assign collision_o   = collision_r;
  assign release_en_o  = release_en_s;
  assign occupied_o    = occupied_s;
  assign num_pending_o = pending_s;

endmodule

// File: tb/tb_simmem_delay_tracker.sv
// -----------------------------------------------------------------------------
// tb_simmem_delay_tracker
// Scoreboard bench: each applied cycle pushes the expected outputs of a
// behavioural model (busy flag + remaining ticks per entry) into a queue; a
// negedge monitor pops and compares. Directed phases add latency checks.
// -----------------------------------------------------------------------------
module tb_simmem_delay_tracker;

  localparam int NE = 12;  // non-power-of-two so ids 12..15 are out of range
  localparam int NI = 2;
  localparam int DW = 6;
  localparam int R  = 2;
  localparam int IW = 4;
  localparam int PW = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  tick;
  logic [NI-1:0]         in_valid;
  logic [NI-1:0][IW-1:0] in_id;
  logic [NI-1:0][DW-1:0] in_delay;
  logic [NI-1:0]         collision;
  logic [NE-1:0]         released;
  logic [NE-1:0]         release_en;
  logic [NE-1:0]         occupied;
  logic [PW-1:0]         num_pending;

  always #5 clk = ~clk;

  simmem_delay_tracker #(
    .NumEntries    (NE),
    .NumInputs     (NI),
    .DelayWidth    (DW),
    .ReleaseOffset (R)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .tick_i            (tick),
    .in_valid_i        (in_valid),
    .in_id_i           (in_id),
    .in_delay_i        (in_delay),
    .collision_o       (collision),
    .released_onehot_i (released),
    .release_en_o      (release_en),
    .occupied_o        (occupied),
    .num_pending_o     (num_pending)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an entry is busy, and releasable once no ticks remain.
  bit m_busy[NE];
  int m_rem[NE];

  typedef struct packed {
    logic [NI-1:0] coll;
    logic [NE-1:0] rel;
    logic [NE-1:0] occ;
    logic [PW-1:0] pend;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(string name, logic [31:0] got, logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Apply current inputs for one clock edge, advancing the model alongside.
  task automatic step();
    bit   taken[NE];
    int   newd[NE];
    exp_t e;
    int   cnt;
    e = '0;
    for (int i = 0; i < NE; i++) begin
      taken[i] = 1'b0;
      newd[i]  = 0;
    end
    if (rst) begin
      for (int i = 0; i < NE; i++) begin
        m_busy[i] = 1'b0;
        m_rem[i]  = 0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (in_valid[k]) begin
          int id;
          id = int'(in_id[k]);
          if (id < NE && !m_busy[id] && !taken[id]) begin
            taken[id] = 1'b1;
            newd[id]  = int'(in_delay[k]);
          end else begin
            e.coll[k] = 1'b1;
          end
        end
      end
      for (int i = 0; i < NE; i++) begin
        if (taken[i]) begin
          m_busy[i] = 1'b1;
          m_rem[i]  = (newd[i] <= R) ? 0 : newd[i] - R;
        end else if (m_busy[i] && m_rem[i] == 0 && released[i]) begin
          m_busy[i] = 1'b0;
        end else if (m_busy[i] && m_rem[i] > 0 && tick) begin
          m_rem[i] = m_rem[i] - 1;
        end
      end
    end
    @(posedge clk);
    #1;
    cnt = 0;
    for (int i = 0; i < NE; i++) begin
      e.occ[i] = m_busy[i];
      e.rel[i] = m_busy[i] && (m_rem[i] == 0);
      if (m_busy[i]) cnt++;
    end
    e.pend = PW'(cnt);
    exp_q.push_back(e);
  endtask

  task automatic req(int p, int id, int d);
    in_valid[p] = 1'b1;
    in_id[p]    = IW'(id);
    in_delay[p] = DW'(d);
  endtask

  // Monitor: compares every presented cycle against the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({collision, release_en, occupied, num_pending} !== e) begin
        n_err++;
        $display("FAIL cycle_outputs: got coll=%b rel=%b occ=%b pend=%0d, expected coll=%b rel=%b occ=%b pend=%0d",
                 collision, release_en, occupied, num_pending, e.coll, e.rel, e.occ, e.pend);
      end
    end
  end

  initial begin : stim
    int c;
    rst      = 1'b1;
    tick     = 1'b1;
    in_valid = '0;
    in_id    = '0;
    in_delay = '0;
    released = '0;
    step();
    step();
    check("reset_outputs", 32'({collision, release_en, occupied, num_pending}), 32'd0);
    rst = 1'b0;

    // D=10 on id 3: release_en first high 9 cycles after the request edge.
    req(0, 3, 10);
    step();
    in_valid = '0;
    c = 1;
    while (!release_en[3] && c < 20) begin
      step();
      c++;
    end
    check("d10_latency", 32'(c), 32'd9);
    repeat (3) step();
    check("d10_hold", 32'(release_en[3]), 32'd1);
    released[3] = 1'b1;
    step();
    released = '0;
    check("d10_occ_fall", 32'(occupied[3]), 32'd0);
    check("d10_rel_fall", 32'(release_en[3]), 32'd0);

    // Short delays on id 0.
    for (int d = 0; d < 4; d++) begin
      req(0, 0, d);
      step();
      in_valid = '0;
      if (d <= R) begin
        check("short_delay_latency", 32'(release_en[0]), 32'd1);
      end else begin
        check("d3_not_yet", 32'(release_en[0]), 32'd0);
        step();
        check("d3_latency", 32'(release_en[0]), 32'd1);
      end
      released[0] = 1'b1;
      step();
      released = '0;
    end

    // Two ports on the same FREE entry: port 0 wins.
    req(0, 5, 20);
    req(1, 5, 4);
    step();
    in_valid = '0;
    check("same_id_collision", 32'(collision), 32'd2);
    check("same_id_pending", 32'(num_pending), 32'd1);
    step();
    check("collision_pulse_end", 32'(collision), 32'd0);
    // Occupied entry and out-of-range id both collide; id 5 timing unchanged.
    req(0, 13, 3);
    req(1, 5, 1);
    step();
    in_valid = '0;
    check("occupied_and_range_collision", 32'(collision), 32'd3);
    c = 3;
    while (!release_en[5] && c < 40) begin
      step();
      c++;
    end
    check("d20_latency_undisturbed", 32'(c), 32'd19);
    released[5] = 1'b1;
    step();
    released = '0;

    // D=8 with four tick-low cycles mid-count.
    req(0, 7, 8);
    step();
    in_valid = '0;
    c = 1;
    while (!release_en[7] && c < 30) begin
      tick = (c >= 3 && c < 7) ? 1'b0 : 1'b1;
      step();
      c++;
    end
    tick = 1'b1;
    check("tick_gap_latency", 32'(c), 32'd11);
    released[7] = 1'b1;
    step();
    released = '0;

    // Fill every entry with the maximum delay, then reset mid-count.
    for (int i = 0; i < NE; i += 2) begin
      req(0, i, 63);
      req(1, i + 1, 63);
      step();
    end
    in_valid = '0;
    repeat (5) step();
    check("all_occupied", 32'(num_pending), 32'(NE));
    rst = 1'b1;
    req(0, 2, 0);
    step();
    rst      = 1'b0;
    in_valid = '0;
    check("midcount_reset", 32'({collision, release_en, occupied, num_pending}), 32'd0);
    c = 0;
    repeat (70) begin
      step();
      if (release_en != '0) c++;
    end
    check("no_release_after_reset", 32'(c), 32'd0);

    // Randomized traffic.
    repeat (3000) begin
      rst  = ($urandom_range(0, 199) == 0);
      tick = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NI; k++) begin
        in_valid[k] = 1'($urandom_range(0, 1));
        in_id[k]    = IW'($urandom_range(0, 15));
        in_delay[k] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 12));
      end
      released = NE'($urandom);
      step();
    end
    rst      = 1'b0;
    in_valid = '0;
    released = '0;
    step();
    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/simmem_delay_tracker.md
# simmem_delay_tracker

Parametrised per-entry delay tracker for the simulated memory controller. It accepts up to `NumInputs` delay reservations per cycle, each naming an entry of a response bank. Per entry, it counts the programmed delay down under a global tick enable and raises a per-entry release enable until the bank reports the entry released. It replaces fixed-capacity, single-input delay banks and sits between the delay calculator and the response banks on both read and write paths.

## Interface
Parameters:
- `NumEntries`, default 16: tracked entries (bank capacity), ≥2.
- `NumInputs`, default 2: reservation ports per cycle, ≥1.
- `DelayWidth`, default 6: delay field width.
- `ReleaseOffset`, default 2: cycles of surrounding pipeline latency subtracted from every delay; 0 ≤ `ReleaseOffset` < 2^`DelayWidth`.
- `IdWidth`, default `$clog2(NumEntries)`: entry identifier width (derived).

Ports:
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `tick_i`, in, 1: count enable; counters decrement only when high.
- `in_valid_i`, in, `NumInputs`: reservation request per port.
- `in_id_i`, in, `NumInputs` x `IdWidth`: target entry per port.
- `in_delay_i`, in, `NumInputs` x `DelayWidth`: requested delay in cycles per port.
- `collision_o`, out, `NumInputs`: 1-cycle pulse; the port's request was dropped.
- `released_onehot_i`, in, `NumEntries`: bank acknowledges release of entries (multi-hot allowed).
- `release_en_o`, out, `NumEntries`: entry may be released by the bank.
- `occupied_o`, out, `NumEntries`: entry is not FREE.
- `num_pending_o`, out, `$clog2(NumEntries+1)`: population count of `occupied_o`.

## Operation
- Each entry has state FREE, COUNTING or RELEASABLE, plus a `DelayWidth` counter.
- **Acceptance.** A request on port k is accepted iff the target entry is FREE in the current cycle.
  - Same-cycle requests to the same FREE entry: the lowest port index wins. Every loser and every request to a non-FREE entry is dropped.
  - A dropped request pulses `collision_o[k]` in the next cycle.
  - `in_id_i` ≥ `NumEntries` is dropped and also pulses `collision_o[k]`.
- **Accepted delay D with R = `ReleaseOffset`:**
  - If D ≤ R, the entry goes to RELEASABLE and the counter to 0.
  - Otherwise the entry goes to COUNTING and the counter loads D−R, computed in `DelayWidth` bits; it never underflows.
- **COUNTING.** When `tick_i` is high, the counter decrements. On a tick with counter = 1, the entry goes to RELEASABLE and the counter to 0. With `tick_i` low, the counter holds.
- **RELEASABLE.** `release_en_o[i]` is 1. `released_onehot_i[i]` moves the entry to FREE in the next cycle.
- **Ignored release.** `released_onehot_i[i]` on a FREE or COUNTING entry is ignored; the entry's state and counter are unchanged.
- **Release vs. new request, same cycle, same entry.** The entry is not FREE at sampling, so the request collides. The release still takes effect.
- `occupied_o[i]` = state ≠ FREE. `num_pending_o` is combinational from the registered state.

## Timing
- Reset (`rst_i` high at a clock edge):
  - All entries FREE, counters 0.
  - `release_en_o`, `occupied_o`, `num_pending_o` and `collision_o` are all 0 in the following cycle.
- Reset mid-operation drops all pending entries with no release; requests in the reset cycle are ignored.
- All outputs are registered state or a combinational function of it; there is no input-to-output combinational path.
- Request accepted at edge t, with `tick_i` constantly high: `release_en_o` is first high in cycle t + max(1, D−R+1). Examples with R=2:
  - D=0..2 gives t+1.
  - D=3 gives t+2.
  - D=10 gives t+9.
- Each low-`tick_i` cycle during COUNTING adds exactly one cycle.
- `occupied_o` rises in cycle t+1. After release at edge r, it falls in cycle r+1, and the entry can accept a new request sampled at edge r+1.
- `collision_o` is a single-cycle pulse in the cycle after the dropped request.

## Structure
- `simmem_pkg` gains:
  - the `delay_entry_state_e` enum (FREE/COUNTING/RELEASABLE);
  - default constants for `NumInputs`, `ReleaseOffset` and tracker capacity;
  - the per-bank instantiation values for read and write paths.
- Sub-module `simmem_delay_tracker_entry`: one entry's FSM and counter. Its inputs are load strobe, load delay, `tick_i` and release. Its outputs are state-derived `release_en` and `occupied`.
- Top level holds port arbitration and collision logic, the `NumEntries` entry instances, and the popcount.

## Test plan
- Reset, then port 0 reserves id 3, D=10, R=2, tick high → `release_en_o[3]` rises exactly 9 cycles after the request edge and holds until `released_onehot_i[3]`; `occupied_o[3]` falls the cycle after.
- D ∈ {0,1,2} on id 0 → `release_en_o[0]` high at t+1. D=3 → high at t+2.
- Ports 0 and 1 both reserve id 5 in one cycle → port 0 accepted. `collision_o` = 2'b10 for one cycle. `num_pending_o`=1.
- Request to an occupied entry, and to id ≥ `NumEntries`, → collision pulse. The existing entry's counter and its release timing are unchanged.
- D=8, `tick_i` low for 4 cycles mid-count → release is delayed by exactly 4 cycles.
- All entries reserved with D=`2^DelayWidth−1`, `rst_i` asserted mid-count → all outputs 0 the next cycle, and no `release_en_o` ever rises for them.
